vga_timing_gen: RTL and testbench

- Generates VGA raster timing for the monochrome bitmap path: hsync, vsync, active-video flag, and the pixel coordinates posx/posy.
- Sits directly upstream of the bitmap controller, which turns posx/posy into a screen-memory address and pixel value.
- Divides the system clock down to a pixel-rate enable, so the display path runs on one clock.
- Defaults give 640x480@60 from a 50 MHz clock with CLK_DIV=2.

---
 rtl/vga_timing_gen.sv | 102 ++++++++++
 tb/tb_vga_timing_gen.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate enable from a clock divider, h/v counters,
// registered sync, active-video, coordinate and line/frame start outputs.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0,
    parameter int unsigned CLK_DIV  = 2
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_en,
    output logic [9:0] posx,
    output logic [8:0] posy,
    output logic       hsync,
    output logic       vsync,
    output logic       active,
    output logic       line_start,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    // Counters hold the pixel to present on the next tick, so the first tick after
    // reset shows (0,0) and outputs for pixel (h,v) register on the tick edge itself.
    logic [DIV_W-1:0] r_div;
    logic [9:0]       r_hcount;
    logic [9:0]       r_vcount;

    logic       w_tick;
    logic       w_act;
    logic       w_hs;
    logic       w_vs;
    logic [9:0] w_hnext;
    logic [9:0] w_vnext;

    always_comb begin
        w_tick  = (r_div == DIV_LAST);
        w_act   = (r_hcount < H_ACT) && (r_vcount < V_ACT);
        w_hs    = (r_hcount >= HS_START) && (r_hcount < HS_END);
        w_vs    = (r_vcount >= VS_START) && (r_vcount < VS_END);
        w_hnext = r_hcount + 10'd1;
        w_vnext = r_vcount;
        if (r_hcount == H_LAST) begin
            w_hnext = '0;
            w_vnext = (r_vcount == V_LAST) ? '0 : r_vcount + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div       <= '0;
            r_hcount    <= '0;
            r_vcount    <= '0;
            pix_en      <= 1'b0;
            posx        <= '0;
            posy        <= '0;
            active      <= 1'b0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_en      <= w_tick;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (w_tick) begin
                r_div       <= '0;
                r_hcount    <= w_hnext;
                r_vcount    <= w_vnext;
                active      <= w_act;
                posx        <= w_act ? r_hcount : '0;
                posy        <= w_act ? r_vcount[8:0] : '0;
                hsync       <= w_hs ? HS_POL : ~HS_POL;
                vsync       <= w_vs ? VS_POL : ~VS_POL;
                line_start  <= (r_hcount == '0);
                frame_start <= (r_hcount == '0) && (r_vcount == '0);
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: three parameter sets, each with randomized reset
// episodes; expected outputs come from pixel-index arithmetic, checked every clock.
module tb_vga_timing_gen;

    // cfg 0: defaults; cfg 1: small raster, CLK_DIV=3; cfg 2: CLK_DIV=1, positive syncs,
    // tall vertical blanking so vcount passes 512.
    localparam int HA_A [3] = '{640, 16, 8};
    localparam int HF_A [3] = '{16,  4,  2};
    localparam int HS_A [3] = '{96,  6,  3};
    localparam int HB_A [3] = '{48,  6,  3};
    localparam int VA_A [3] = '{480, 12, 4};
    localparam int VF_A [3] = '{10,  2,  510};
    localparam int VS_A [3] = '{2,   2,  2};
    localparam int VB_A [3] = '{33,  3,  4};
    localparam int HP_A [3] = '{0,   0,  1};
    localparam int VP_A [3] = '{0,   0,  1};
    localparam int CD_A [3] = '{2,   3,  1};

    typedef struct packed {
        logic       pix_en;
        logic [9:0] posx;
        logic [8:0] posy;
        logic       hsync;
        logic       vsync;
        logic       active;
        logic       ls;
        logic       fs;
    } exp_t;

    logic clk;
    int   checks   = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // k = clock edges since the last edge that sampled rst high (0 on that edge).
    function automatic exp_t model(input int c, input longint unsigned k);
        exp_t e;
        longint unsigned n;
        int ht, vt, h, v;
        ht = HA_A[c] + HF_A[c] + HS_A[c] + HB_A[c];
        vt = VA_A[c] + VF_A[c] + VS_A[c] + VB_A[c];
        e = '0;
        e.hsync = ~1'(HP_A[c]);
        e.vsync = ~1'(VP_A[c]);
        if (k < longint'(CD_A[c])) return e;
        n = k / longint'(CD_A[c]) - 1;
        h = int'(n % longint'(ht));
        v = int'((n / longint'(ht)) % longint'(vt));
        e.pix_en = (k % longint'(CD_A[c])) == 0;
        e.active = (h < HA_A[c]) && (v < VA_A[c]);
        e.posx   = e.active ? 10'(h) : 10'd0;
        e.posy   = e.active ? 9'(v) : 9'd0;
        e.hsync  = (h >= HA_A[c] + HF_A[c] && h < HA_A[c] + HF_A[c] + HS_A[c]) ?
                   1'(HP_A[c]) : ~1'(HP_A[c]);
        e.vsync  = (v >= VA_A[c] + VF_A[c] && v < VA_A[c] + VF_A[c] + VS_A[c]) ?
                   1'(VP_A[c]) : ~1'(VP_A[c]);
        e.ls     = e.pix_en && (h == 0);
        e.fs     = e.pix_en && (h == 0) && (v == 0);
        return e;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int HT = HA_A[g] + HF_A[g] + HS_A[g] + HB_A[g];
        localparam int VT = VA_A[g] + VF_A[g] + VS_A[g] + VB_A[g];
        localparam int CD = CD_A[g];

        logic       rst_g;
        logic       pe, hs, vs, act, ls, fs;
        logic [9:0] px;
        logic [8:0] py;
        logic       sdone = 1'b0;
        int         nprint = 0;
        longint unsigned k = 0;
        exp_t       q[$];

        vga_timing_gen #(
            .H_ACTIVE(HA_A[g]), .H_FP(HF_A[g]), .H_SYNC(HS_A[g]), .H_BP(HB_A[g]),
            .V_ACTIVE(VA_A[g]), .V_FP(VF_A[g]), .V_SYNC(VS_A[g]), .V_BP(VB_A[g]),
            .HS_POL(1'(HP_A[g])), .VS_POL(1'(VP_A[g])), .CLK_DIV(CD_A[g])
        ) u_dut (
            .clk(clk), .rst(rst_g), .pix_en(pe), .posx(px), .posy(py),
            .hsync(hs), .vsync(vs), .active(act), .line_start(ls), .frame_start(fs)
        );

        // Drive rst for the coming edge and push the response that edge must produce.
        task automatic step(input logic r);
            rst_g = r;
            if (r) k = 0;
            else   k = k + 1;
            q.push_back(model(g, k));
            @(negedge clk);
        endtask

        task automatic run(input int n);
            for (int i = 0; i < n; i++) step(1'b0);
        endtask

        initial begin
            int first_len, tgt;
            first_len = CD * HT * VT + 2 * CD * HT;
            if (first_len > 6000) first_len = 6000;
            repeat (5) step(1'b1);
            run(first_len);
            for (int e = 0; e < 4; e++) begin
                repeat ($urandom_range(1, 3)) step(1'b1);
                run($urandom_range(1, 2 * CD * HT));
            end
            // Reset, advance to a pixel inside hsync, then pulse rst for one clock there.
            step(1'b1);
            tgt = CD * ((VT / 2) * HT + HA_A[g] + HF_A[g] + 2);
            if (tgt > 20000) tgt = CD * (HA_A[g] + HF_A[g] + 2);
            run(tgt);
            step(1'b1);
            run(3 * CD * HT);
            rst_g = 1'b0;
            repeat (3) @(negedge clk);
            sdone = 1'b1;
        end

        initial begin
            exp_t e, a;
            forever begin
                @(posedge clk);
                #1;
                if (q.size() > 0) begin
                    e = q.pop_front();
                    a = '{pix_en: pe, posx: px, posy: py, hsync: hs, vsync: vs,
                          active: act, ls: ls, fs: fs};
                    checks++;
                    if (a !== e) begin
                        failures++;
                        if (nprint < 20) begin
                            nprint++;
                            $display("FAIL out_cfg%0d t=%0t got pe=%b x=%0d y=%0d hs=%b vs=%b act=%b ls=%b fs=%b exp pe=%b x=%0d y=%0d hs=%b vs=%b act=%b ls=%b fs=%b",
                                     g, $time, a.pix_en, a.posx, a.posy, a.hsync, a.vsync,
                                     a.active, a.ls, a.fs, e.pix_en, e.posx, e.posy,
                                     e.hsync, e.vsync, e.active, e.ls, e.fs);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int cyc;
        cyc = 0;
        while (!(cfg[0].sdone && cfg[1].sdone && cfg[2].sdone) && cyc < 60000) begin
            @(posedge clk);
            cyc++;
        end
        if (!(cfg[0].sdone && cfg[1].sdone && cfg[2].sdone)) begin
            failures++;
            $display("FAIL timeout got done=%b%b%b exp done=111",
                     cfg[0].sdone, cfg[1].sdone, cfg[2].sdone);
        end
        checks++;
        if (cfg[0].q.size() + cfg[1].q.size() + cfg[2].q.size() != 0) begin
            failures++;
            $display("FAIL drain got pending=%0d exp pending=0",
                     cfg[0].q.size() + cfg[1].q.size() + cfg[2].q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
